// File: rtl/icsp_loader_pkg.sv
// Shared ICSP loader constants: command codes, frame sizes, FSM states.
package icsp_loader_pkg;

    localparam int unsigned INST_WIDTH_C    = 12;
    localparam int unsigned PC_WIDTH_C      = 9;

    localparam int unsigned ICSP_FRAME_BITS = 16;
    localparam int unsigned ICSP_CMD_BITS   = 6;
    localparam int unsigned ICSP_CNT_W      = $clog2(ICSP_FRAME_BITS);

    localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_LOAD = 6'h02;
    localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_READ = 6'h04;
    localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_INC  = 6'h06;
    localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_PROG = 6'h08;

    typedef enum logic [2:0] {
        ICSP_ST_IDLE = 3'd0,
        ICSP_ST_CMD  = 3'd1,
        ICSP_ST_LOAD = 3'd2,
        ICSP_ST_READ = 3'd3,
        ICSP_ST_PROG = 3'd4
    } icsp_state_e;

endpackage

// File: rtl/icsp_loader_sync.sv
// Two-flop synchronizer for one asynchronous ICSP pin, with rise/fall pulses
// derived from the synchronized value.
module icsp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    // Synchronizer chain plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/icsp_loader.sv
// ICSP serial programming loader for the PIC16C55 program memory.
// Optional build macro ICSP_VERIFY_EN enables post-program verify (verifyErr).
module icsp_loader
    import icsp_loader_pkg::*;
#(
    parameter int unsigned INST_WIDTH  = INST_WIDTH_C,
    parameter int unsigned PC_WIDTH    = PC_WIDTH_C,
    parameter int unsigned PROG_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  progEn,
    input  logic                  icspClk,
    input  logic                  icspDataIn,
    output logic                  icspDataOut,
    output logic                  icspDataOe,
    output logic [PC_WIDTH-1:0]   memAddr,
    output logic [INST_WIDTH-1:0] memWrData,
    output logic                  memWrEn,
    input  logic [INST_WIDTH-1:0] memRdData,
    output logic                  cpuHold,
    output logic                  busy,
    output logic                  verifyErr
);

    logic pen_s, pen_rise, pen_fall;
    logic clk_s, clk_rise, clk_fall;
    logic din_s, din_rise, din_fall;
    logic unused_edges;

    icsp_sync u_sync_pen (.clk(clk), .rst_n(rst_n), .async_i(progEn),
                          .sync_o(pen_s), .rise_o(pen_rise), .fall_o(pen_fall));
    icsp_sync u_sync_clk (.clk(clk), .rst_n(rst_n), .async_i(icspClk),
                          .sync_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall));
    icsp_sync u_sync_din (.clk(clk), .rst_n(rst_n), .async_i(icspDataIn),
                          .sync_o(din_s), .rise_o(din_rise), .fall_o(din_fall));

    icsp_state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]        addr_q, addr_d;
    logic [ICSP_FRAME_BITS-1:0] sh_q, sh_d;
    logic [ICSP_CNT_W-1:0]      cnt_q, cnt_d;
    logic [INST_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       wr_q, wr_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 pcnt_q, pcnt_d;
    logic                       oe_q, oe_d;
    logic                       dout_q, dout_d;
    logic [ICSP_CMD_BITS-1:0]   cmd;
    logic [ICSP_FRAME_BITS-1:0] rd_frame;

    // Read frame as shifted out on rising edges: start 0, data LSB first, pad 0s.
    always_comb begin
        rd_frame                 = '0;
        rd_frame[INST_WIDTH:1]   = memRdData;
    end

    // Next-state and datapath: progEn low overrides every other event.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        busy_d  = busy_q;
        pcnt_d  = pcnt_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        cmd     = {din_s, sh_q[ICSP_CMD_BITS-2:0]};

        if (!pen_s) begin
            state_d = ICSP_ST_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
        end else begin
            case (state_q)
                ICSP_ST_IDLE: begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = ICSP_ST_CMD;
                end
                ICSP_ST_CMD: begin
                    if (clk_fall) begin
                        sh_d[cnt_q] = din_s;
                        if (cnt_q == ICSP_CNT_W'(ICSP_CMD_BITS - 1)) begin
                            cnt_d = '0;
                            case (cmd)
                                ICSP_CMD_LOAD: state_d = ICSP_ST_LOAD;
                                ICSP_CMD_READ: begin
                                    sh_d    = rd_frame;
                                    oe_d    = 1'b1;
                                    state_d = ICSP_ST_READ;
                                end
                                ICSP_CMD_INC:  addr_d = addr_q + PC_WIDTH'(1);
                                ICSP_CMD_PROG: begin
                                    wr_d    = 1'b1;
                                    busy_d  = 1'b1;
                                    pcnt_d  = 8'(PROG_CYCLES - 1);
                                    state_d = ICSP_ST_PROG;
                                end
                                default: ;
                            endcase
                        end else begin
                            cnt_d = cnt_q + ICSP_CNT_W'(1);
                        end
                    end
                end
                ICSP_ST_LOAD: begin
                    if (clk_fall) begin
                        sh_d[cnt_q] = din_s;
                        if (cnt_q == ICSP_CNT_W'(ICSP_FRAME_BITS - 1)) begin
                            wdata_d = sh_d[INST_WIDTH:1];
                            cnt_d   = '0;
                            state_d = ICSP_ST_CMD;
                        end else begin
                            cnt_d = cnt_q + ICSP_CNT_W'(1);
                        end
                    end
                end
                ICSP_ST_READ: begin
                    if (clk_rise) begin
                        dout_d = sh_q[cnt_q];
                    end else if (clk_fall) begin
                        if (cnt_q == ICSP_CNT_W'(ICSP_FRAME_BITS - 1)) begin
                            oe_d    = 1'b0;
                            dout_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = ICSP_ST_CMD;
                        end else begin
                            cnt_d = cnt_q + ICSP_CNT_W'(1);
                        end
                    end
                end
                ICSP_ST_PROG: begin
                    if (pcnt_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = ICSP_ST_CMD;
                    end else begin
                        pcnt_d = pcnt_q - 8'd1;
                    end
                end
                default: state_d = ICSP_ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ICSP_ST_IDLE;
            addr_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            pcnt_q  <= '0;
            oe_q    <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            pcnt_q  <= pcnt_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

    // Gating with the synchronized progEn makes an abort take effect the
    // same cycle: a pending strobe is suppressed and busy drops immediately.
    assign cpuHold     = pen_s;
    assign memAddr     = addr_q;
    assign memWrData   = wdata_q;
    assign memWrEn     = wr_q & pen_s;
    assign busy        = busy_q & pen_s;
    assign icspDataOe  = oe_q & pen_s;
    assign icspDataOut = dout_q;

`ifdef ICSP_VERIFY_EN
    logic verr_q, verr_d;

    // Sticky verify flag: compare on the last busy clock, clear on progEn rise.
    always_comb begin
        verr_d = verr_q;
        if (pen_rise) begin
            verr_d = 1'b0;
        end else if (pen_s && state_q == ICSP_ST_PROG && pcnt_q == '0
                     && memRdData != wdata_q) begin
            verr_d = 1'b1;
        end
    end

    // Verify flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) verr_q <= 1'b0;
        else        verr_q <= verr_d;
    end

    assign verifyErr    = verr_q;
    assign unused_edges = pen_fall ^ clk_s ^ din_rise ^ din_fall;
`else
    assign verifyErr    = 1'b0;
    assign unused_edges = pen_rise ^ pen_fall ^ clk_s ^ din_rise ^ din_fall;
`endif

endmodule

// File: doc/icsp_loader.md
Name: icsp_loader

Overview:
- Serial in-circuit programming loader that sits directly upstream of the program memory feeding the PIC16C55 core.
- Receives ICSP-style bit-serial commands and data, and issues single-cycle word writes into program memory.
- Supports read-back of program memory and holds the CPU in reset while programming mode is active.
- Runs entirely on the core clock; the ICSP pins are asynchronous inputs and are synchronized internally.

Parameters:
- INST_WIDTH, 12, program word width; must equal `INST_WIDTH.
- PC_WIDTH, 9, program address width; must equal `PC_WIDTH.
- PROG_CYCLES, 8, clocks the block stays busy after a write pulse; legal range 1..255.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- progEn  input  1  programming-mode request (MCLR/VPP equivalent); asynchronous, synchronized internally.
- icspClk  input  1  serial clock from programmer; asynchronous.
- icspDataIn  input  1  serial data from programmer; asynchronous.
- icspDataOut  output  1  serial read data.
- icspDataOe  output  1  pad output enable for icspDataOut.
- memAddr  output  PC_WIDTH  program-memory address.
- memWrData  output  INST_WIDTH  program-memory write data.
- memWrEn  output  1  one-clock write strobe.
- memRdData  input  INST_WIDTH  combinational program-memory read of memAddr.
- cpuHold  output  1  holds the core in reset while high.
- busy  output  1  write in progress.
- verifyErr  output  1  sticky verify-failure flag (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; internal address, shift register and bit counter 0; FSM in IDLE.
- Synchronization: progEn, icspClk and icspDataIn each pass through a 2-FF synchronizer.
- Edge detection: icspClk rise/fall pulses come from the synchronized value, so input-to-action latency is 3 clk.
- Sampling: icspDataIn is sampled on the icspClk falling edge. icspDataOut updates on the icspClk rising edge.
- Bit order: all frames are LSB first.
- cpuHold equals the synchronized progEn.
- progEn low forces IDLE from any state, with priority over every other event. It clears the bit counter and icspDataOe, and suppresses any write not yet strobed. busy drops the same cycle.
- FSM states:
  - IDLE: address := 0. When synchronized progEn goes high -> CMD.
  - CMD: shift 6 bits, then decode.
    - 0x02 -> LOAD.
    - 0x04 -> READ; latch memRdData into the shift register.
    - 0x06 -> memAddr += 1 (wraps from 2^PC_WIDTH-1 to 0); stay in CMD.
    - 0x08 -> PROG.
    - Any other code: ignored; stay in CMD with the counter cleared.
  - LOAD: shift a 16-bit frame: bit0 start (ignored), bits 1..12 data, bits 13..15 stop/pad (ignored). Once 16 bits are in, memWrData := bits 12:1; -> CMD.
  - READ: icspDataOe = 1 for the whole frame. The 16 rising edges drive 0, then data bits 0..11, then 0,0,0. After the 16th falling edge, icspDataOe := 0; -> CMD.
  - PROG: memWrEn = 1 on the first clk only, with memAddr and memWrData stable. busy = 1 for PROG_CYCLES clks. icspClk edges during PROG are ignored. -> CMD on expiry.
- Fall/rise simultaneity cannot occur: synchronized edges are mutually exclusive.
- Address is never changed by LOAD, READ or PROG; only 0x06 and IDLE modify it.

Optional Feature:
- Macro ICSP_VERIFY_EN.
- Defined: on the last busy clk of PROG, compare memRdData with memWrData. On mismatch, set verifyErr. verifyErr is sticky until rst_n or a new progEn rising edge.
- Undefined: verifyErr is tied to 0 and the compare logic is absent.

Decomposition:
- Shared constants go in define.v: ICSP_CMD_LOAD=6'h02, ICSP_CMD_READ=6'h04, ICSP_CMD_INC=6'h06, ICSP_CMD_PROG=6'h08, ICSP_FRAME_BITS=16, ICSP_CMD_BITS=6, and the FSM state encodings (ICSP_ST_*). Reuse `INST_WIDTH and `PC_WIDTH.
- One sub-module: icsp_sync. It is instantiated three times; each instance provides a 2-FF synchronizer plus rise/fall pulse outputs.

Test Plan:
- Reset then progEn=1: cpuHold=1 after 2 clk; memAddr=0; all other outputs 0.
- Load/program: 0x02 + frame data 12'hA5C, then 0x08 -> memWrEn exactly one clk with memAddr=0, memWrData=12'hA5C; busy=1 for 8 clk.
- Increment and wrap: 511 × 0x06 -> memAddr=9'h1FF; one more 0x06 -> memAddr=0.
- Read: memRdData=12'h3C1 at address 5, then 0x04 -> icspDataOut sequence 0,1,0,0,0,0,0,1,1,1,1,0,0,0,0,0; icspDataOe high for exactly the frame.
- Abort: drop progEn after 8 bits of a LOAD frame -> IDLE; no memWrEn; memAddr=0 on re-entry. Illegal command 0x3F -> ignored, and the next 0x06 still works.
- Verify (ICSP_VERIFY_EN): memory model drops writes, PROG of 12'h001 -> verifyErr=1 and stays 1 until the next progEn rise. With the macro undefined, verifyErr stays 0.
